// File: rtl/atmega_eep_persist_ctl_if.sv
// Control, EEPROM external-port and NV-store signals of the EEPROM persistence controller.
// The master modport is the controller side; the slave modport is the EEPROM/NV/CPU side.
interface atmega_eep_persist_ctl_if;
  logic        restore_i;
  logic        modified_i;
  logic        busy_o;
  logic        done_o;
  logic        cpu_stall_o;
  logic        eep_en_o;
  logic [16:0] eep_addr_o;
  logic        eep_wr_o;
  logic [7:0]  eep_wdata_o;
  logic        eep_rd_o;
  logic [7:0]  eep_rdata_i;
  logic        nv_req_o;
  logic        nv_we_o;
  logic [16:0] nv_addr_o;
  logic [7:0]  nv_wdata_o;
  logic [7:0]  nv_rdata_i;
  logic        nv_ack_i;

  modport master (
    input  restore_i, modified_i, eep_rdata_i, nv_rdata_i, nv_ack_i,
    output busy_o, done_o, cpu_stall_o, eep_en_o, eep_addr_o, eep_wr_o, eep_wdata_o,
           eep_rd_o, nv_req_o, nv_we_o, nv_addr_o, nv_wdata_o
  );

  modport slave (
    output restore_i, modified_i, eep_rdata_i, nv_rdata_i, nv_ack_i,
    input  busy_o, done_o, cpu_stall_o, eep_en_o, eep_addr_o, eep_wr_o, eep_wdata_o,
           eep_rd_o, nv_req_o, nv_we_o, nv_addr_o, nv_wdata_o
  );
endinterface

// File: rtl/atmega_eep_persist_ctl.sv
// EEPROM persistence sequencer: restores EEPROM from the NV store and saves it back
// once CPU writes have been quiet for IDLE_DLY cycles.
module atmega_eep_persist_ctl #(
  parameter int unsigned EEP_SIZE     = 512,
  parameter int unsigned IDLE_DLY     = 1024,
  parameter bit          AUTO_RESTORE = 1'b1
) (
  input logic                      clk_i,
  input logic                      rst_i,
  atmega_eep_persist_ctl_if.master bus
);

  localparam int unsigned BUS_AW = 17;
  localparam int unsigned AW     = (EEP_SIZE > 1) ? $clog2(EEP_SIZE) : 1;
  localparam int unsigned DW     = (IDLE_DLY > 1) ? $clog2(IDLE_DLY) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(EEP_SIZE - 1);
  localparam logic [DW-1:0] DLY_LOAD  = DW'(IDLE_DLY - 1);

  typedef enum logic [2:0] {IDLE, R_REQ, R_WR, S_WAIT, S_RD, S_CAP, S_REQ, FIN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dly_q, dly_d;
  logic          pend_q, pend_d;
  logic          boot_q;
  logic [7:0]    eep_wdata_q, eep_wdata_d;
  logic [7:0]    nv_wdata_q, nv_wdata_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          eep_en_q, eep_en_d, eep_wr_q, eep_wr_d, eep_rd_q, eep_rd_d;
  logic          nv_req_q, nv_req_d, nv_we_q, nv_we_d;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    dly_d       = dly_q;
    pend_d      = pend_q;
    eep_wdata_d = eep_wdata_q;
    nv_wdata_d  = nv_wdata_q;

    // A CPU write landing behind the save cursor must trigger another save
    if (bus.modified_i && (state_q inside {S_RD, S_CAP, S_REQ})) pend_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (bus.restore_i || (AUTO_RESTORE && boot_q)) begin
          state_d = R_REQ;
          addr_d  = '0;
          if (bus.modified_i) pend_d = 1'b1;
        end else if (bus.modified_i || pend_q) begin
          state_d = S_WAIT;
          dly_d   = DLY_LOAD;
          pend_d  = 1'b0;
        end
      end
      R_REQ: begin
        if (bus.nv_ack_i) begin
          eep_wdata_d = bus.nv_rdata_i;
          state_d     = R_WR;
        end
      end
      R_WR: begin
        if (addr_q == LAST_ADDR) begin
          state_d = FIN;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = R_REQ;
        end
      end
      S_WAIT: begin
        if (bus.modified_i) begin
          dly_d = DLY_LOAD;
        end else if (dly_q == '0) begin
          addr_d  = '0;
          state_d = S_RD;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      S_RD:  state_d = S_CAP;
      S_CAP: begin
        nv_wdata_d = bus.eep_rdata_i;
        state_d    = S_REQ;
      end
      S_REQ: begin
        if (bus.nv_ack_i) begin
          if (addr_q == LAST_ADDR) begin
            state_d = FIN;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_RD;
          end
        end
      end
      FIN: begin
        addr_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d != IDLE);
    done_d   = (state_d == FIN);
    eep_en_d = (state_d inside {R_WR, S_RD, S_CAP});
    eep_wr_d = (state_d == R_WR);
    eep_rd_d = (state_d == S_RD);
    nv_req_d = (state_d inside {R_REQ, S_REQ});
    nv_we_d  = (state_d == S_REQ);
  end

  // State and output registers; reset abandons any NV transfer in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      dly_q       <= '0;
      pend_q      <= 1'b0;
      boot_q      <= 1'b1;
      eep_wdata_q <= '0;
      nv_wdata_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      eep_en_q    <= 1'b0;
      eep_wr_q    <= 1'b0;
      eep_rd_q    <= 1'b0;
      nv_req_q    <= 1'b0;
      nv_we_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      dly_q       <= dly_d;
      pend_q      <= pend_d;
      boot_q      <= 1'b0;
      eep_wdata_q <= eep_wdata_d;
      nv_wdata_q  <= nv_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      eep_en_q    <= eep_en_d;
      eep_wr_q    <= eep_wr_d;
      eep_rd_q    <= eep_rd_d;
      nv_req_q    <= nv_req_d;
      nv_we_q     <= nv_we_d;
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.cpu_stall_o = eep_en_q;
  assign bus.eep_en_o    = eep_en_q;
  assign bus.eep_addr_o  = BUS_AW'(addr_q);
  assign bus.eep_wr_o    = eep_wr_q;
  assign bus.eep_wdata_o = eep_wdata_q;
  assign bus.eep_rd_o    = eep_rd_q;
  assign bus.nv_req_o    = nv_req_q;
  assign bus.nv_we_o     = nv_we_q;
  assign bus.nv_addr_o   = BUS_AW'(addr_q);
  assign bus.nv_wdata_o  = nv_wdata_q;

endmodule

// File: tb/tb_atmega_eep_persist_ctl.sv
// Bench for atmega_eep_persist_ctl: array models of the EEPROM and NV store, random NV
// ack latency, a table of quiet-period scenarios and hand-written multi-cycle sequences.
module tb_atmega_eep_persist_ctl;
  localparam int unsigned N   = 512;
  localparam int unsigned DLY = 16;
  localparam int unsigned LIM = 20000;
  localparam int unsigned N2  = 64;

  typedef struct { int a; int d; } nvw_t;
  typedef struct { int pulses; int gap; int exp_lat; } row_t;

  logic clk_i = 1'b0;
  logic rst_i, rst2;
  always #5 clk_i = ~clk_i;

  atmega_eep_persist_ctl_if bus ();
  atmega_eep_persist_ctl_if bus2 ();

  atmega_eep_persist_ctl #(.EEP_SIZE(N), .IDLE_DLY(DLY), .AUTO_RESTORE(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  atmega_eep_persist_ctl #(.EEP_SIZE(N2), .IDLE_DLY(4), .AUTO_RESTORE(1'b0)) dut2 (
    .clk_i(clk_i), .rst_i(rst2), .bus(bus2));

  logic [7:0] eep_mem [N];
  logic [7:0] nv_mem  [N];
  logic [7:0] snap    [N];
  nvw_t       wr_q[$];
  int         nv_rd_cnt = 0;
  int         req_age = 0;
  int         rnd_dly = 0;
  int         ack_fix = 3;
  logic       init_mem = 1'b0;
  logic       cpu_mod = 1'b0;
  logic       cpu_we = 1'b0;
  logic       echo_mod = 1'b0;
  int         cpu_a = 0;
  logic [7:0] cpu_d = 8'h00;
  logic [7:0] eep_rdata = 8'h00;
  int         errors = 0;
  int         checks = 0;
  int         prot_err = 0;
  int         done_cnt = 0;

  // NV store answers after a per-transfer latency; EEPROM echoes a modified pulse on ext writes
  always_comb begin
    bus.nv_ack_i    = bus.nv_req_o && (req_age >= ((ack_fix < 0) ? rnd_dly : ack_fix));
    bus.nv_rdata_i  = bus.nv_ack_i ? nv_mem[bus.nv_addr_o[8:0]] : ~nv_mem[bus.nv_addr_o[8:0]];
    bus.eep_rdata_i = eep_rdata;
    bus.modified_i  = cpu_mod | echo_mod;
    bus2.nv_ack_i    = bus2.nv_req_o;
    bus2.nv_rdata_i  = 8'h5A;
    bus2.eep_rdata_i = 8'h3C;
  end

  always @(posedge clk_i) begin
    echo_mod <= bus.eep_en_o && bus.eep_wr_o;
    if (init_mem)
      for (int i = 0; i < int'(N); i++) begin
        nv_mem[i]  <= 8'(i) ^ 8'hA5;
        eep_mem[i] <= 8'h00;
      end
    if (bus.nv_req_o && !bus.nv_ack_i) req_age <= req_age + 1;
    else req_age <= 0;
    if (bus.nv_req_o && bus.nv_ack_i) begin
      rnd_dly <= int'($urandom_range(0, 3));
      if (bus.nv_we_o) begin
        nv_mem[bus.nv_addr_o[8:0]] <= bus.nv_wdata_o;
        wr_q.push_back('{a: int'(bus.nv_addr_o), d: int'(bus.nv_wdata_o)});
      end else begin
        nv_rd_cnt <= nv_rd_cnt + 1;
      end
    end
    if (bus.eep_en_o && bus.eep_wr_o) eep_mem[bus.eep_addr_o[8:0]] <= bus.eep_wdata_o;
    if (cpu_we) eep_mem[cpu_a[8:0]] <= cpu_d;
    eep_rdata <= (bus.eep_en_o && bus.eep_rd_o) ? eep_mem[bus.eep_addr_o[8:0]] : 8'($urandom);
  end

  // Handshake and port-ownership rules, sampled mid-cycle
  logic        p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0, p_done = 1'b0;
  logic [16:0] p_addr = '0;
  logic [7:0]  p_wd = '0;
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (bus.cpu_stall_o !== bus.eep_en_o) prot_err++;
      if (bus.eep_en_o && bus.nv_req_o) prot_err++;
      if ((bus.eep_wr_o || bus.eep_rd_o) && !bus.eep_en_o) prot_err++;
      if (p_req && p_ack && bus.nv_req_o) prot_err++;
      if (p_req && !p_ack && (!bus.nv_req_o || bus.nv_addr_o != p_addr || bus.nv_we_o != p_we ||
                              (p_we && bus.nv_wdata_o != p_wd))) prot_err++;
      if (p_done && bus.done_o) prot_err++;
      if (bus.done_o) done_cnt++;
    end
    p_req  = bus.nv_req_o;
    p_ack  = bus.nv_ack_i;
    p_we   = bus.nv_we_o;
    p_addr = bus.nv_addr_o;
    p_wd   = bus.nv_wdata_o;
    p_done = bus.done_o;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!bus.done_o && k < int'(LIM)) begin
      @(negedge clk_i);
      k++;
    end
    check({name, "_done_seen"}, int'(bus.done_o), 1);
  endtask

  task automatic req_latency(output int k);
    k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (!bus.nv_req_o && k < 200);
  endtask

  // Caller sits on a negedge; the pulse is sampled by the next posedge
  task automatic cpu_write(input int a, input logic [7:0] d, input logic with_restore);
    cpu_we = 1'b1; cpu_a = a; cpu_d = d; cpu_mod = 1'b1; bus.restore_i = with_restore;
    @(negedge clk_i);
    cpu_we = 1'b0; cpu_mod = 1'b0; bus.restore_i = 1'b0;
  endtask

  task automatic check_pass(input string name, input int base);
    int bad = 0;
    for (int i = 0; i < int'(N); i++)
      if (base + i >= wr_q.size() || wr_q[base+i].a != i || wr_q[base+i].d != int'(snap[i])) bad++;
    check({name, "_bytes"}, bad, 0);
  endtask

  initial begin
    row_t        rows [4];
    int          lat, base, d0, rd0, bad, k;
    logic [57:0] v;

    rows[0] = '{pulses: 1,  gap: 1,  exp_lat: int'(DLY) + 2};
    rows[1] = '{pulses: 10, gap: 10, exp_lat: int'(DLY) + 2};
    rows[2] = '{pulses: 4,  gap: 15, exp_lat: int'(DLY) + 2};
    rows[3] = '{pulses: 3,  gap: 1,  exp_lat: int'(DLY) + 2};

    rst_i = 1'b1; rst2 = 1'b1;
    bus.restore_i = 1'b0; bus2.restore_i = 1'b0; bus2.modified_i = 1'b0;
    init_mem = 1'b1;
    @(negedge clk_i);
    init_mem = 1'b0;
    @(negedge clk_i);
    check("rst_busy", int'(bus.busy_o), 0);
    check("rst_nv_req", int'(bus.nv_req_o), 0);
    check("rst_eep_en", int'(bus.eep_en_o), 0);
    check("rst_done", int'(bus.done_o), 0);

    // Automatic restore after reset release, NV ack after 3 wait cycles
    rst_i = 1'b0;
    wait_done("restore");
    bad = 0;
    for (int n = 0; n < int'(N); n++) if (eep_mem[n] != (8'(n) ^ 8'hA5)) bad++;
    check("restore_bytes", bad, 0);
    check("restore_nv_reads", nv_rd_cnt, int'(N));
    repeat (40) @(negedge clk_i);
    check("restore_then_idle", int'(bus.busy_o), 0);
    check("restore_done_pulses", done_cnt, 1);
    check("restore_no_save", wr_q.size(), 0);

    // Quiet-period table: save must start IDLE_DLY+2 cycles after the last modified pulse
    ack_fix = -1;
    foreach (rows[r]) begin
      base = wr_q.size();
      d0   = done_cnt;
      for (int p = 0; p < rows[r].pulses; p++) begin
        if (p != 0) repeat (rows[r].gap - 1) @(negedge clk_i);
        cpu_write(int'($urandom_range(0, N - 1)), 8'($urandom), 1'b0);
      end
      snap = eep_mem;
      req_latency(lat);
      check($sformatf("row%0d_latency", r), lat, rows[r].exp_lat);
      wait_done($sformatf("row%0d", r));
      check_pass($sformatf("row%0d", r), base);
      check($sformatf("row%0d_writes", r), wr_q.size() - base, int'(N));
      repeat (4) @(negedge clk_i);
      check($sformatf("row%0d_done_pulses", r), done_cnt - d0, 1);
    end

    // Ack in the very first request cycle of every transfer
    ack_fix = 0;
    base = wr_q.size();
    cpu_write(5, 8'h5C, 1'b0);
    snap = eep_mem;
    wait_done("ack0");
    check_pass("ack0", base);
    check("ack0_writes", wr_q.size() - base, int'(N));
    ack_fix = -1;

    // Write mid-save at address 100 (plus an ignored restore) forces a second full save
    @(negedge clk_i);
    base = wr_q.size(); rd0 = nv_rd_cnt; d0 = done_cnt;
    cpu_write(200, 8'h11, 1'b0);
    snap = eep_mem;
    k = 0;
    while (!(bus.nv_req_o && bus.nv_we_o && bus.nv_addr_o == 17'd100) && k < int'(LIM)) begin
      @(negedge clk_i);
      k++;
    end
    check("mid_reach_100", int'(bus.nv_addr_o), 100);
    cpu_write(7, ~snap[7], 1'b1);
    wait_done("mid_first");
    check_pass("mid_first", base);
    req_latency(lat);
    check("mid_resave_latency", lat, int'(DLY) + 4);
    snap = eep_mem;
    wait_done("mid_second");
    check_pass("mid_second", base + int'(N));
    repeat (4) @(negedge clk_i);
    check("mid_done_pulses", done_cnt - d0, 2);
    check("mid_restore_ignored", nv_rd_cnt - rd0, 0);

    // Restore and modified together in IDLE: restore first, then a save
    snap = nv_mem;
    rd0 = nv_rd_cnt;
    base = wr_q.size();
    cpu_write(3, 8'hEE, 1'b1);
    wait_done("rm_restore");
    bad = 0;
    for (int n = 0; n < int'(N); n++) if (eep_mem[n] != snap[n]) bad++;
    check("rm_restore_bytes", bad, 0);
    check("rm_nv_reads", nv_rd_cnt - rd0, int'(N));
    req_latency(lat);
    check("rm_save_latency", lat, int'(DLY) + 4);
    snap = eep_mem;
    wait_done("rm_save");
    check_pass("rm_save", base);

    // Second instance: asynchronous reset mid-save, no auto restore afterwards
    rst2 = 1'b0;
    repeat (5) @(negedge clk_i);
    check("inst2_idle_after_reset", int'(bus2.busy_o), 0);
    bus2.modified_i = 1'b1;
    @(negedge clk_i);
    bus2.modified_i = 1'b0;
    k = 0;
    while (!(bus2.nv_req_o && bus2.nv_addr_o == 17'd37) && k < 2000) begin
      @(negedge clk_i);
      k++;
    end
    check("inst2_reach_37", int'(bus2.nv_addr_o), 37);
    rst2 = 1'b1;
    #1;
    v = {bus2.busy_o, bus2.done_o, bus2.cpu_stall_o, bus2.eep_en_o, bus2.eep_wr_o, bus2.eep_rd_o,
         bus2.nv_req_o, bus2.nv_we_o, bus2.eep_addr_o, bus2.nv_addr_o, bus2.eep_wdata_o,
         bus2.nv_wdata_o};
    check("inst2_async_outputs_zero", $countones(v), 0);
    @(negedge clk_i);
    rst2 = 1'b0;
    k = 0;
    repeat (30) begin
      @(negedge clk_i);
      if (bus2.busy_o || bus2.nv_req_o) k++;
    end
    check("inst2_stays_idle", k, 0);

    check("protocol", prot_err, 0);
    bad = 0;
    for (int n = 0; n < int'(N); n++) if (nv_mem[n] != eep_mem[n]) bad++;
    check("nv_matches_eep", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
